// File: rtl/multicycle_controller.sv
// Control unit for the multicycle ARM datapath: main sequencing FSM, ALU decode,
// registered condition-execute bit and NZCV flag register with optional memory wait states.
module multicycle_controller #(
    parameter int MEM_WAIT  = 1,
    parameter int ALUCTRL_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [19:0]          Instr,
    input  logic [3:0]           ALUFlags,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic [1:0]           RegSrc,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 Illegal,
    output logic [3:0]           State
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECUTER = 4'd6;
    localparam logic [3:0] EXECUTEI = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;

    logic [3:0] state_q, state_d;
    logic       condex_q, condex_d;
    logic [3:0] flags_q, flags_d;

    // Instr carries bits [31:12], so bit k of the instruction sits at Instr[k-12].
    logic [3:0] cond_s, cmd_s, rd_s;
    logic [1:0] op_s;
    logic       imm_s, sbit_s, ready_s, is_exec_s;

    assign cond_s    = Instr[19:16];
    assign op_s      = Instr[15:14];
    assign imm_s     = Instr[13];
    assign cmd_s     = Instr[12:9];
    assign sbit_s    = Instr[8];
    assign rd_s      = Instr[3:0];
    assign ready_s   = (MEM_WAIT != 0) ? MemReady : 1'b1;
    assign is_exec_s = (state_q == EXECUTER) || (state_q == EXECUTEI);

    function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        logic res;
        {n, z, cy, v} = f;
        case (c)
            4'b0000: res = z;
            4'b0001: res = ~z;
            4'b0010: res = cy;
            4'b0011: res = ~cy;
            4'b0100: res = n;
            4'b0101: res = ~n;
            4'b0110: res = v;
            4'b0111: res = ~v;
            4'b1000: res = cy & ~z;
            4'b1001: res = ~cy | z;
            4'b1010: res = (n == v);
            4'b1011: res = (n != v);
            4'b1100: res = ~z & (n == v);
            4'b1101: res = z | (n != v);
            4'b1110: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    logic [2:0] alu_code_s;
    logic [1:0] flag_w_s;
    logic       no_write_s;

    // ALU operation decode from cmd and S
    always_comb begin
        alu_code_s = 3'd0;
        flag_w_s   = 2'b00;
        no_write_s = 1'b0;
        case (cmd_s)
            4'b0100: begin alu_code_s = 3'd0; flag_w_s = {sbit_s, sbit_s}; end
            4'b0010: begin alu_code_s = 3'd1; flag_w_s = {sbit_s, sbit_s}; end
            4'b0000: begin alu_code_s = 3'd2; flag_w_s = {sbit_s, 1'b0}; end
            4'b1100: begin alu_code_s = 3'd3; flag_w_s = {sbit_s, 1'b0}; end
            4'b0001: begin alu_code_s = 3'd4; flag_w_s = {sbit_s, 1'b0}; end
            4'b1010: begin alu_code_s = 3'd1; flag_w_s = 2'b11; no_write_s = 1'b1; end
            default: begin alu_code_s = 3'd0; flag_w_s = 2'b00; no_write_s = 1'b0; end
        endcase
    end

    // Next-state, condition latch and flag update
    always_comb begin
        state_d  = FETCH;
        condex_d = condex_q;
        flags_d  = flags_q;
        case (state_q)
            FETCH:    state_d = ready_s ? DECODE : FETCH;
            DECODE: begin
                condex_d = cond_check(cond_s, flags_q);
                case (op_s)
                    2'b01:   state_d = MEMADR;
                    2'b00:   state_d = imm_s ? EXECUTEI : EXECUTER;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = sbit_s ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = ready_s ? MEMWB : MEMREAD;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = ready_s ? FETCH : MEMWRITE;
            EXECUTER, EXECUTEI: begin
                state_d = ALUWB;
                if (condex_q) begin
                    flags_d[3:2] = flag_w_s[1] ? ALUFlags[3:2] : flags_q[3:2];
                    flags_d[1:0] = flag_w_s[0] ? ALUFlags[1:0] : flags_q[1:0];
                end else begin
                    flags_d = flags_q;
                end
            end
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    // State, condition and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            condex_q <= 1'b0;
            flags_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            condex_q <= condex_d;
            flags_q  <= flags_d;
        end
    end

    logic reg_w_s, mem_w_s, branch_s, fetch_pc_s, pc_reg_s;

    // Per-state datapath controls; write enables are gated below
    always_comb begin
        reg_w_s    = 1'b0;
        mem_w_s    = 1'b0;
        branch_s   = 1'b0;
        fetch_pc_s = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        RegSrc     = 2'b00;
        ALUSrcA    = 2'd0;
        ALUSrcB    = 2'd0;
        ResultSrc  = 2'd0;
        Illegal    = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcA    = 2'd1;
                ALUSrcB    = 2'd2;
                ResultSrc  = 2'd2;
                IRWrite    = ready_s;
                fetch_pc_s = ready_s;
            end
            DECODE: begin
                ALUSrcA   = 2'd1;
                ALUSrcB   = 2'd2;
                ResultSrc = 2'd2;
                RegSrc    = {op_s == 2'b01, op_s == 2'b10};
                Illegal   = (op_s == 2'b11);
            end
            MEMADR:   ALUSrcB = 2'd1;
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'd1;
                reg_w_s   = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc  = 1'b1;
                mem_w_s = 1'b1;
            end
            EXECUTER: ALUSrcB = 2'd0;
            EXECUTEI: ALUSrcB = 2'd1;
            ALUWB:    reg_w_s = ~no_write_s;
            BRANCH: begin
                ALUSrcB   = 2'd1;
                ResultSrc = 2'd2;
                branch_s  = 1'b1;
            end
            default: begin
                reg_w_s = 1'b0;
            end
        endcase
    end

    assign pc_reg_s   = reg_w_s & condex_q & (rd_s == 4'd15);
    assign RegWrite   = reg_w_s & condex_q & (rd_s != 4'd15);
    assign MemWrite   = mem_w_s & condex_q;
    assign PCWrite    = fetch_pc_s | (branch_s & condex_q) | pc_reg_s;
    assign ImmSrc     = Instr[13:12];
    assign ALUControl = is_exec_s ? ALUCTRL_W'(alu_code_s) : {ALUCTRL_W{1'b0}};
    assign State      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: an instruction-level model expands each
// instruction into its expected per-cycle control trace, which is compared to the DUT.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0]  RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0]  ALUControl;
    logic [3:0]  State;

    multicycle_controller #(.MEM_WAIT(1), .ALUCTRL_W(3)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
        .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Planned trace for one instruction
    int          n_cyc;
    logic        drv_ready [64];
    logic [3:0]  drv_flags [64];
    logic [31:0] exp_vec   [64];
    logic [31:0] obs_vec   [64];
    logic [3:0]  mdl_flags;
    logic [19:0] cur_instr;

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input int st, input logic rdy, input logic [3:0] fl,
                        input logic regw, input logic memw, input logic pcw, input logic irw,
                        input logic ill, input logic adr, input int aluc, input int srca,
                        input int srcb, input int ress, input logic [1:0] regsrc);
        drv_ready[n_cyc] = rdy;
        drv_flags[n_cyc] = fl;
        exp_vec[n_cyc] = {9'd0, 4'(st), regw, memw, pcw, irw, ill, adr, 3'(aluc),
                          2'(srca), 2'(srcb), 2'(ress), regsrc, cur_instr[13:12]};
        n_cyc++;
    endtask

    // Expand one instruction into cycles; af is ALUFlags presented in the execute cycle
    task automatic plan(input logic [19:0] ins, input int fw, input int mw, input logic [3:0] af);
        int   op, cmd, rd, ctl;
        logic ib, s, ce, nw, wb;
        logic [1:0] fwr;
        cur_instr = ins;
        op  = int'(ins[15:14]);
        ib  = ins[13];
        cmd = int'(ins[12:9]);
        s   = ins[8];
        rd  = int'(ins[3:0]);
        ce  = cond_ok(ins[19:16], mdl_flags);
        n_cyc = 0;
        for (int k = 0; k <= fw; k++)
            push(0, k == fw, 4'($urandom), 0, 0, k == fw, k == fw, 0, 0, 0, 1, 2, 2, 2'b00);
        push(1, 1'($urandom), 4'($urandom), 0, 0, 0, 0, op == 3, 0, 0, 1, 2, 2,
             {op == 1, op == 2});
        if (op == 1) begin
            push(2, 1'($urandom), 4'($urandom), 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00);
            if (s) begin
                for (int k = 0; k <= mw; k++)
                    push(3, k == mw, 4'($urandom), 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00);
                push(4, 1'($urandom), 4'($urandom), ce && rd != 15, 0, ce && rd == 15,
                     0, 0, 0, 0, 0, 0, 1, 2'b00);
            end else begin
                for (int k = 0; k <= mw; k++)
                    push(5, k == mw, 4'($urandom), 0, ce, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00);
            end
        end else if (op == 0) begin
            nw = 0;
            case (cmd)
                4:  begin ctl = 0; fwr = {s, s}; end
                2:  begin ctl = 1; fwr = {s, s}; end
                0:  begin ctl = 2; fwr = {s, 1'b0}; end
                12: begin ctl = 3; fwr = {s, 1'b0}; end
                1:  begin ctl = 4; fwr = {s, 1'b0}; end
                10: begin ctl = 1; fwr = 2'b11; nw = 1; end
                default: begin ctl = 0; fwr = 2'b00; end
            endcase
            push(ib ? 7 : 6, 1'($urandom), af, 0, 0, 0, 0, 0, 0, ctl, 0, ib ? 1 : 0, 0, 2'b00);
            if (ce && fwr[1]) mdl_flags[3:2] = af[3:2];
            if (ce && fwr[0]) mdl_flags[1:0] = af[1:0];
            wb = ce && !nw;
            push(8, 1'($urandom), 4'($urandom), wb && rd != 15, 0, wb && rd == 15,
                 0, 0, 0, 0, 0, 0, 0, 2'b00);
        end else if (op == 2) begin
            push(9, 1'($urandom), 4'($urandom), 0, 0, ce, 0, 0, 0, 0, 0, 1, 2, 2'b00);
        end
    endtask

    task automatic run_plan();
        for (int i = 0; i < n_cyc; i++) begin
            @(negedge clk);
            Instr    = cur_instr;
            MemReady = drv_ready[i];
            ALUFlags = drv_flags[i];
            #1;
            obs_vec[i] = {9'd0, State, RegWrite, MemWrite, PCWrite, IRWrite, Illegal, AdrSrc,
                          ALUControl, ALUSrcA, ALUSrcB, ResultSrc, RegSrc, ImmSrc};
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; MemReady = 1'b0; ALUFlags = 4'd0; Instr = 20'hE0821;
        mdl_flags = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++;
            if (State !== 4'd0 || RegWrite !== 1'b0 || MemWrite !== 1'b0 || PCWrite !== 1'b0)
                $display("FAIL reset st=%0d rw=%b mw=%b pc=%b want st=0 all 0",
                         State, RegWrite, MemWrite, PCWrite);
            else passed++;
        end
        reset = 1'b0;
    endtask

    task automatic test_add();
        plan(20'hE0821, 0, 0, 4'($urandom));
        run_plan();
        for (int i = 0; i < n_cyc; i++) begin
            total++;
            if (obs_vec[i] !== exp_vec[i]) $display("FAIL add cyc%0d got %h want %h", i, obs_vec[i], exp_vec[i]);
            else passed++;
        end
    endtask

    task automatic test_ldr_wait();
        plan(20'hE5904, 1, 2, 4'($urandom));
        run_plan();
        for (int i = 0; i < n_cyc; i++) begin
            total++;
            if (obs_vec[i] !== exp_vec[i]) $display("FAIL ldr_wait cyc%0d got %h want %h", i, obs_vec[i], exp_vec[i]);
            else passed++;
        end
    endtask

    task automatic test_cmp_addeq();
        logic [19:0] seq [3];
        logic [3:0]  afs [3];
        seq = '{20'hE1510, 20'h00821, 20'hE082F};
        afs = '{4'b0100, 4'b1111, 4'b0000};
        for (int t = 0; t < 3; t++) begin
            plan(seq[t], 0, 0, afs[t]);
            run_plan();
            for (int i = 0; i < n_cyc; i++) begin
                total++;
                if (obs_vec[i] !== exp_vec[i])
                    $display("FAIL cmp_addeq ins%0d cyc%0d got %h want %h", t, i, obs_vec[i], exp_vec[i]);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [3:0] seen [4];
        Instr = 20'hE5904;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            MemReady = (i == 0);
            #1 seen[i] = State;
        end
        total++;
        if (seen[3] !== 4'd3) $display("FAIL mid_read_entry st=%0d want 3", seen[3]);
        else passed++;
        reset = 1'b1; MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            total++;
            if ((i > 0 && State !== 4'd0) || RegWrite !== 1'b0 || MemWrite !== 1'b0)
                $display("FAIL reset_mid r%0d st=%0d rw=%b mw=%b want st=0 rw=0 mw=0",
                         i, State, RegWrite, MemWrite);
            else passed++;
        end
        @(negedge clk); #1;
        reset = 1'b0;
        mdl_flags = 4'd0;
        // Z was set by the CMP earlier; after reset the ADDEQ must not write
        for (int t = 0; t < 2; t++) begin
            plan(20'h00821, 0, 0, 4'b0100);
            run_plan();
            for (int i = 0; i < n_cyc; i++) begin
                total++;
                if (obs_vec[i] !== exp_vec[i])
                    $display("FAIL post_reset_addeq ins%0d cyc%0d got %h want %h", t, i, obs_vec[i], exp_vec[i]);
                else passed++;
            end
        end
    endtask

    task automatic test_branch_illegal();
        logic [19:0] seq [2];
        seq = '{20'hEA000, 20'hEC000};
        for (int t = 0; t < 2; t++) begin
            plan(seq[t], 0, 0, 4'($urandom));
            run_plan();
            for (int i = 0; i < n_cyc; i++) begin
                total++;
                if (obs_vec[i] !== exp_vec[i])
                    $display("FAIL branch_illegal ins%0d cyc%0d got %h want %h", t, i, obs_vec[i], exp_vec[i]);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] ins;
        for (int t = 0; t < 60; t++) begin
            ins = 20'($urandom);
            if ($urandom_range(0, 3) == 0) ins[19:16] = 4'hE;
            if ($urandom_range(0, 4) == 0) ins[3:0] = 4'hF;
            plan(ins, $urandom_range(0, 2), $urandom_range(0, 2), 4'($urandom));
            run_plan();
            for (int i = 0; i < n_cyc; i++) begin
                total++;
                if (obs_vec[i] !== exp_vec[i])
                    $display("FAIL random ins%0d=%h cyc%0d got %h want %h", t, ins, i, obs_vec[i], exp_vec[i]);
                else passed++;
            end
        end
        @(negedge clk); MemReady = 1'b0; #1;
        total++;
        if (State !== 4'd0) $display("FAIL final_fetch st=%0d want 0", State);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldr_wait();
        test_cmp_addeq();
        test_reset_mid_read();
        test_branch_illegal();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
